sd_sector_sched: RTL and testbench
==================================

Name: sd_sector_sched

Overview:
- Scheduler in front of the single SD sector reader.
- Shares the reader between two requesters, A (cartridge ROM loader) and B (save/backup loader).
- Each request is a multi-sector burst: start LBA plus sector count. The block issues one sector read at a time, chains consecutive LBAs, and tags every returned byte with the requester id and burst byte offset.
- Sits between the loader logic and the reader's rstart/rsector/rbusy/rdone/outen interface.

Parameters:
CNT_W  16  width of sector-count field; max burst = 2^CNT_W-1 sectors

Ports:
clk  in  1  system clock; same clock as the sector reader
rst  in  1  reset, asynchronous, active-high
a_req  in  1  requester A start strobe; sampled only while a_busy=0
a_lba  in  32  A start sector, sampled with a_req
a_cnt  in  CNT_W  A sector count, sampled with a_req
a_busy  out  1  A request pending or in service
a_done  out  1  one-cycle pulse: A burst complete
b_req, b_lba, b_cnt, b_busy, b_done  —  same as A, for requester B
sd_rstart  out  1  one-cycle read start to reader
sd_rsector  out  32  sector number to reader; held stable from sd_rstart until sd_rdone
sd_rbusy  in  1  reader not ready (high during card init and while reading)
sd_rdone  in  1  reader one-cycle sector-complete pulse
sd_outen  in  1  reader byte strobe
sd_outaddr  in  9  reader byte index 0..511
sd_outbyte  in  8  reader byte
dout_en  out  1  byte valid
dout_id  out  1  0=A, 1=B
dout_off  out  CNT_W+9  byte offset within burst = {sector_idx, sd_outaddr}
dout_byte  out  8  data byte

Behaviour:
- Reset values: all outputs 0; state IDLE; pend_a=pend_b=0; last_grant=1, so A wins the first tie.
- Accept: x_req & ~x_busy latches lba/cnt into per-requester pending registers and sets pend_x. x_busy=1 from the next cycle until done.
- x_req while x_busy=1 is ignored.
- x_busy is a registered pend_x and drops in the same cycle x_done pulses. x_req in that cycle is accepted.
- State machine: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, WAIT_RDY.
- IDLE:
  - Arbitration happens only when sd_rbusy=0 and pend_a|pend_b.
  - Round-robin: if both are pending, grant the one not equal to last_grant; otherwise grant the single pending one. Update last_grant.
  - Load cur_lba, remaining=cnt, sector_idx=0.
  - If cnt==0: pulse x_done next cycle, clear pend_x, stay IDLE, no reader access.
  - Otherwise go to ISSUE.
- ISSUE: sd_rstart=1 for exactly one cycle, sd_rsector=cur_lba; go to WAIT_ACK.
- WAIT_ACK: wait for sd_rbusy=1, then go to WAIT_DONE. No rstart re-issue.
- WAIT_DONE:
  - On sd_rdone: remaining-=1; sector_idx+=1.
  - If remaining was 1: pulse x_done, clear pend_x, go to IDLE.
  - Else: cur_lba+=1 (mod 2^32, wraps 0xFFFFFFFF→0), go to WAIT_RDY.
- WAIT_RDY: when sd_rbusy=0, go to ISSUE. The burst keeps the reader; the other requester waits until burst end, so there is no mid-burst preemption.
- Data path, registered with 1-cycle latency:
  - dout_en <= sd_outen & (state==WAIT_DONE).
  - dout_byte <= sd_outbyte, dout_id <= grant, dout_off <= {sector_idx, sd_outaddr}.
  - Bytes outside WAIT_DONE are dropped.
- Reader-internal retries (timeouts) are invisible here: the block simply waits for sd_rdone. There is no scheduler timeout.
- Reset mid-burst: asynchronous clear of everything. The reader is reset by its own rstn; no partial done pulse.

Test Plan:
- Card init holds sd_rbusy=1 for 1000 cycles; a_req lba=0x100 cnt=1 → no sd_rstart until sd_rbusy=0, then one sd_rstart with sd_rsector=0x100; 512 dout_en with id=0, off 0..511; a_done once; a_busy low same cycle.
- a_req lba=0x10 cnt=3 → sd_rsector 0x10,0x11,0x12 in order; dout_off runs 0..1535 contiguous; exactly 3 sd_rstart pulses, one a_done.
- a_req and b_req same cycle after reset, cnt=2 each → full A burst first, then B burst; repeat both while idle → B served first (round-robin).
- b_req lba=0xFFFFFFFF cnt=2 → sectors 0xFFFFFFFF then 0x00000000.
- a_req cnt=0 → a_done pulses, no sd_rstart; a_req while a_busy=1 is ignored, with burst parameters unchanged.
- Assert rst in WAIT_DONE halfway through a sector → all outputs 0 immediately; new a_req after release → clean burst from a fresh sd_rstart.

Source files
------------

// File: rtl/sd_sector_sched.sv
// sd_sector_sched
//   Shares the single SD sector reader between two burst requesters,
//   A (cartridge ROM loader) and B (save/backup loader). Each request is a
//   start LBA plus a sector count; bursts are served one sector at a time on
//   consecutive LBAs, round-robin between requesters at burst granularity.
//   Every byte returned by the reader is retagged with the owning requester
//   and its byte offset within the burst.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   a_req/a_lba/a_cnt        requester A start strobe, start sector, count
//   a_busy, a_done           A pending/in service, one-cycle burst-complete
//   b_*                      same as A for requester B
//   sd_rstart, sd_rsector    read start pulse and sector number to the reader
//   sd_rbusy, sd_rdone       reader not-ready level and sector-complete pulse
//   sd_outen/addr/byte       reader byte strobe, byte index, byte value
//   dout_en/id/off/byte      tagged byte stream, one cycle after the reader
module sd_sector_sched #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_req,
    input  logic [31:0]        a_lba,
    input  logic [CNT_W-1:0]   a_cnt,
    output logic               a_busy,
    output logic               a_done,
    input  logic               b_req,
    input  logic [31:0]        b_lba,
    input  logic [CNT_W-1:0]   b_cnt,
    output logic               b_busy,
    output logic               b_done,
    output logic               sd_rstart,
    output logic [31:0]        sd_rsector,
    input  logic               sd_rbusy,
    input  logic               sd_rdone,
    input  logic               sd_outen,
    input  logic [8:0]         sd_outaddr,
    input  logic [7:0]         sd_outbyte,
    output logic               dout_en,
    output logic               dout_id,
    output logic [CNT_W+8:0]   dout_off,
    output logic [7:0]         dout_byte
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        WAIT_RDY  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic               pend_a_q, pend_a_d;
    logic               pend_b_q, pend_b_d;
    logic [31:0]        a_lba_q, a_lba_d;
    logic [31:0]        b_lba_q, b_lba_d;
    logic [CNT_W-1:0]   a_cnt_q, a_cnt_d;
    logic [CNT_W-1:0]   b_cnt_q, b_cnt_d;
    logic               last_grant_q, last_grant_d;
    logic               grant_q, grant_d;
    logic [31:0]        cur_lba_q, cur_lba_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   sector_idx_q, sector_idx_d;
    logic               a_done_q, a_done_d;
    logic               b_done_q, b_done_d;
    logic               rstart_q, rstart_d;
    logic               dout_en_q, dout_en_d;
    logic               dout_id_q, dout_id_d;
    logic [CNT_W+8:0]   dout_off_q, dout_off_d;
    logic [7:0]         dout_byte_q, dout_byte_d;

    logic               pick_b_s;
    logic [CNT_W-1:0]   sel_cnt_s;

    // Next-state: request capture, arbitration and burst sequencing.
    always_comb begin
        state_d      = state_q;
        pend_a_d     = pend_a_q;
        pend_b_d     = pend_b_q;
        a_lba_d      = a_lba_q;
        b_lba_d      = b_lba_q;
        a_cnt_d      = a_cnt_q;
        b_cnt_d      = b_cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cur_lba_d    = cur_lba_q;
        remaining_d  = remaining_q;
        sector_idx_d = sector_idx_q;
        a_done_d     = 1'b0;
        b_done_d     = 1'b0;
        pick_b_s     = 1'b0;
        sel_cnt_s    = CNT_ZERO;

        // Capture a new request only when the requester has nothing pending;
        // a pending request can never be cleared in the same cycle, so the
        // two updates of pend_x below never collide.
        if (a_req && !pend_a_q) begin
            pend_a_d = 1'b1;
            a_lba_d  = a_lba;
            a_cnt_d  = a_cnt;
        end else begin
            pend_a_d = pend_a_q;
        end
        if (b_req && !pend_b_q) begin
            pend_b_d = 1'b1;
            b_lba_d  = b_lba;
            b_cnt_d  = b_cnt;
        end else begin
            pend_b_d = pend_b_q;
        end

        case (state_q)
            IDLE: begin
                if (!sd_rbusy && (pend_a_q || pend_b_q)) begin
                    // On a tie, B wins only if A had the previous grant.
                    pick_b_s     = pend_b_q && (!pend_a_q || !last_grant_q);
                    sel_cnt_s    = pick_b_s ? b_cnt_q : a_cnt_q;
                    grant_d      = pick_b_s;
                    last_grant_d = pick_b_s;
                    cur_lba_d    = pick_b_s ? b_lba_q : a_lba_q;
                    remaining_d  = sel_cnt_s;
                    sector_idx_d = CNT_ZERO;
                    if (sel_cnt_s == CNT_ZERO) begin
                        // Empty burst completes without touching the reader.
                        if (pick_b_s) begin
                            b_done_d = 1'b1;
                            pend_b_d = 1'b0;
                        end else begin
                            a_done_d = 1'b1;
                            pend_a_d = 1'b0;
                        end
                        state_d = IDLE;
                    end else begin
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (sd_rbusy) begin
                    state_d = WAIT_DONE;
                end else begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_DONE: begin
                if (sd_rdone) begin
                    remaining_d  = remaining_q - CNT_ONE;
                    sector_idx_d = sector_idx_q + CNT_ONE;
                    if (remaining_q == CNT_ONE) begin
                        if (grant_q) begin
                            b_done_d = 1'b1;
                            pend_b_d = 1'b0;
                        end else begin
                            a_done_d = 1'b1;
                            pend_a_d = 1'b0;
                        end
                        state_d = IDLE;
                    end else begin
                        // LBA arithmetic wraps naturally at 2^32.
                        cur_lba_d = cur_lba_q + 32'd1;
                        state_d   = WAIT_RDY;
                    end
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_RDY: begin
                if (!sd_rbusy) begin
                    state_d = ISSUE;
                end else begin
                    state_d = WAIT_RDY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output-side next values: start pulse and the retagged byte stream.
    always_comb begin
        rstart_d    = (state_d == ISSUE);
        dout_en_d   = sd_outen && (state_q == WAIT_DONE);
        dout_id_d   = grant_q;
        dout_off_d  = {sector_idx_q, sd_outaddr};
        dout_byte_d = sd_outbyte;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_a_q     <= 1'b0;
            pend_b_q     <= 1'b0;
            a_lba_q      <= 32'd0;
            b_lba_q      <= 32'd0;
            a_cnt_q      <= CNT_ZERO;
            b_cnt_q      <= CNT_ZERO;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cur_lba_q    <= 32'd0;
            remaining_q  <= CNT_ZERO;
            sector_idx_q <= CNT_ZERO;
            a_done_q     <= 1'b0;
            b_done_q     <= 1'b0;
            rstart_q     <= 1'b0;
            dout_en_q    <= 1'b0;
            dout_id_q    <= 1'b0;
            dout_off_q   <= {(CNT_W+9){1'b0}};
            dout_byte_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            pend_a_q     <= pend_a_d;
            pend_b_q     <= pend_b_d;
            a_lba_q      <= a_lba_d;
            b_lba_q      <= b_lba_d;
            a_cnt_q      <= a_cnt_d;
            b_cnt_q      <= b_cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cur_lba_q    <= cur_lba_d;
            remaining_q  <= remaining_d;
            sector_idx_q <= sector_idx_d;
            a_done_q     <= a_done_d;
            b_done_q     <= b_done_d;
            rstart_q     <= rstart_d;
            dout_en_q    <= dout_en_d;
            dout_id_q    <= dout_id_d;
            dout_off_q   <= dout_off_d;
            dout_byte_q  <= dout_byte_d;
        end
    end

    // busy is the pending flag itself, so it falls in the done-pulse cycle.
    assign a_busy     = pend_a_q;
    assign b_busy     = pend_b_q;
    assign a_done     = a_done_q;
    assign b_done     = b_done_q;
    assign sd_rstart  = rstart_q;
    assign sd_rsector = cur_lba_q;
    assign dout_en    = dout_en_q;
    assign dout_id    = dout_id_q;
    assign dout_off   = dout_off_q;
    assign dout_byte  = dout_byte_q;

endmodule

// File: tb/tb_sd_sector_sched.sv
// Scoreboard bench for sd_sector_sched: a behavioural sector reader answers
// read starts; expected sectors, tagged bytes and done pulses are queued when
// requests are driven and popped as the scheduler produces them.
module tb_sd_sector_sched;

    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_req, b_req;
    logic [31:0]       a_lba, b_lba;
    logic [CNT_W-1:0]  a_cnt, b_cnt;
    logic              a_busy, a_done, b_busy, b_done;
    logic              sd_rstart;
    logic [31:0]       sd_rsector;
    logic              sd_rbusy, sd_rdone, sd_outen;
    logic [8:0]        sd_outaddr;
    logic [7:0]        sd_outbyte;
    logic              dout_en, dout_id;
    logic [CNT_W+8:0]  dout_off;
    logic [7:0]        dout_byte;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] sec_q[$];
    logic [33:0] byte_q[$];
    logic [1:0]  done_q[$];
    bit          exp_last;
    logic        init_hold;

    sd_sector_sched #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_lba(a_lba), .a_cnt(a_cnt), .a_busy(a_busy), .a_done(a_done),
        .b_req(b_req), .b_lba(b_lba), .b_cnt(b_cnt), .b_busy(b_busy), .b_done(b_done),
        .sd_rstart(sd_rstart), .sd_rsector(sd_rsector), .sd_rbusy(sd_rbusy),
        .sd_rdone(sd_rdone), .sd_outen(sd_outen), .sd_outaddr(sd_outaddr),
        .sd_outbyte(sd_outbyte),
        .dout_en(dout_en), .dout_id(dout_id), .dout_off(dout_off), .dout_byte(dout_byte)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] byte_fn(input logic [31:0] sec, input logic [8:0] addr);
        return sec[7:0] ^ addr[7:0] ^ {addr[8], 7'h2B};
    endfunction

    // Behavioural reader: busy one cycle after rstart, short latency,
    // 512 bytes, rdone pulse, then one more busy cycle.
    int          rd_st;
    int          rd_wait;
    logic [31:0] rd_sec;
    logic [9:0]  rd_addr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_st <= 0; rd_wait <= 0; rd_sec <= 32'd0; rd_addr <= 10'd0;
        end else begin
            case (rd_st)
                0: if (sd_rstart && !sd_rbusy) begin
                       rd_st <= 1; rd_sec <= sd_rsector; rd_wait <= 0;
                   end
                1: if (rd_wait == 3) begin rd_st <= 2; rd_addr <= 10'd0; end
                   else rd_wait <= rd_wait + 1;
                2: begin
                       if (rd_addr == 10'd511) rd_st <= 3;
                       rd_addr <= rd_addr + 10'd1;
                   end
                3: rd_st <= 4;
                default: rd_st <= 0;
            endcase
        end
    end

    assign sd_rbusy   = init_hold | (rd_st != 0);
    assign sd_outen   = (rd_st == 2);
    assign sd_outaddr = rd_addr[8:0];
    assign sd_outbyte = byte_fn(rd_sec, rd_addr[8:0]);
    assign sd_rdone   = (rd_st == 3);

    // Monitor: compare every DUT event against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (sd_rstart) begin
                check_val("rstart_while_rbusy", {63'd0, sd_rbusy}, 64'd0);
                if (sec_q.size() == 0) check_val("unexpected_rstart", sec_q.size(), 64'd1);
                else check_val("rsector", sd_rsector, sec_q.pop_front());
            end
            if (dout_en) begin
                if (byte_q.size() == 0) check_val("unexpected_byte", byte_q.size(), 64'd1);
                else check_val("dout_id_off_byte", {dout_id, dout_off, dout_byte}, byte_q.pop_front());
            end
            if (a_done || b_done) begin
                check_val("busy_at_done", {63'd0, (a_done ? a_busy : b_busy)}, 64'd0);
                if (done_q.size() == 0) check_val("unexpected_done", done_q.size(), 64'd1);
                else check_val("done_id", {b_done, a_done}, done_q.pop_front());
            end
        end
    end

    task automatic exp_burst(input bit id, input logic [31:0] lba, input int cnt);
        logic [31:0] sec;
        logic [15:0] sidx;
        logic [8:0]  ad;
        for (int s = 0; s < cnt; s++) begin
            sec  = lba + 32'(s);
            sidx = 16'(s);
            sec_q.push_back(sec);
            for (int a = 0; a < 512; a++) begin
                ad = 9'(a);
                byte_q.push_back({id, sidx, ad, byte_fn(sec, ad)});
            end
        end
        done_q.push_back(id ? 2'b10 : 2'b01);
        exp_last = id;
    endtask

    task automatic drive_req(input bit do_a, input logic [31:0] la, input int ca,
                             input bit do_b, input logic [31:0] lb, input int cb);
        @(negedge clk);
        a_req = do_a; a_lba = la; a_cnt = 16'(ca);
        b_req = do_b; b_lba = lb; b_cnt = 16'(cb);
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0;
    endtask

    // Both requesters at once: the one that did not get the last grant goes first.
    task automatic tie(input logic [31:0] la, input int ca, input logic [31:0] lb, input int cb);
        if (exp_last) begin
            exp_burst(1'b0, la, ca); exp_burst(1'b1, lb, cb);
        end else begin
            exp_burst(1'b1, lb, cb); exp_burst(1'b0, la, ca);
        end
        drive_req(1'b1, la, ca, 1'b1, lb, cb);
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n = 0;
        while ((sec_q.size() != 0 || byte_q.size() != 0 || done_q.size() != 0 ||
                a_busy || b_busy || sd_rbusy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, {63'd0, (n < budget)}, 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ctrl"}, {57'd0, a_busy, a_done, b_busy, b_done, sd_rstart, dout_en, dout_id}, 64'd0);
        check_val({tag, "_rsector"}, {32'd0, sd_rsector}, 64'd0);
        check_val({tag, "_dout"}, {31'd0, dout_off, dout_byte}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        exp_last = 1'b1;
    endtask

    initial begin
        int n;
        rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
        a_lba = 32'd0; b_lba = 32'd0; a_cnt = 16'd0; b_cnt = 16'd0;
        init_hold = 1'b1;
        do_reset();

        // Card init: nothing may be issued while the reader is busy.
        exp_burst(1'b0, 32'h100, 1);
        drive_req(1'b1, 32'h100, 1, 1'b0, 32'd0, 0);
        check_val("a_busy_after_accept", {63'd0, a_busy}, 64'd1);
        repeat (1000) @(negedge clk);
        check_val("init_no_issue", sec_q.size(), 64'd1);
        init_hold = 1'b0;
        wait_quiet("init_burst", 2000);

        // Multi-sector chaining.
        exp_burst(1'b0, 32'h10, 3);
        drive_req(1'b1, 32'h10, 3, 1'b0, 32'd0, 0);
        wait_quiet("chain3", 4000);

        // Round-robin after reset: A first, then B.
        do_reset();
        tie(32'h40, 2, 32'h80, 2);
        wait_quiet("tie1", 6000);
        // A alone takes the last grant, so the next tie goes to B first.
        exp_burst(1'b0, 32'h60, 1);
        drive_req(1'b1, 32'h60, 1, 1'b0, 32'd0, 0);
        wait_quiet("a_single", 2000);
        tie(32'h44, 1, 32'h84, 1);
        wait_quiet("tie2", 4000);

        // LBA wrap.
        exp_burst(1'b1, 32'hFFFF_FFFF, 2);
        drive_req(1'b0, 32'd0, 0, 1'b1, 32'hFFFF_FFFF, 2);
        wait_quiet("wrap", 4000);

        // Request while busy is ignored.
        exp_burst(1'b0, 32'h200, 2);
        drive_req(1'b1, 32'h200, 2, 1'b0, 32'd0, 0);
        repeat (5) @(negedge clk);
        drive_req(1'b1, 32'h999, 5, 1'b0, 32'd0, 0);
        check_val("busy_during_ignore", {63'd0, a_busy}, 64'd1);
        wait_quiet("ignored_req", 4000);

        // Zero-length burst.
        exp_burst(1'b0, 32'h300, 0);
        drive_req(1'b1, 32'h300, 0, 1'b0, 32'd0, 0);
        wait_quiet("cnt0", 100);

        // Reset in the middle of a sector.
        exp_burst(1'b0, 32'h500, 2);
        drive_req(1'b1, 32'h500, 2, 1'b0, 32'd0, 0);
        n = 0;
        while (!(sd_outen && sd_outaddr == 9'd256) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_val("reach_mid_sector", {63'd0, (n < 2000)}, 64'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("mid_reset");
        sec_q.delete(); byte_q.delete(); done_q.delete();
        exp_last = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_burst(1'b0, 32'h700, 1);
        drive_req(1'b1, 32'h700, 1, 1'b0, 32'd0, 0);
        wait_quiet("after_reset", 2000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
